ce_timer_bank: RTL and testbench

CE_TIMER_BANK -- requirements
Module: ce_timer_bank

---
 rtl/ce_timer_bank.sv | 110 +++++++++++
 tb/tb_ce_timer_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_timer_bank.sv
// Bank of programmable clock-enable dividers with a square-wave tap per channel,
// plus a phase-selected interrupt driven by one channel's enable pulses.
module ce_timer_bank #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 16,
    parameter int IRQ_SRC    = 2,
    parameter int IRQ_PERIOD = 14,
    parameter int IRQ_PHASE  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    resync,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic                    irq_ack,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       sq,
    output logic                    irq,
    output logic                    irq_pulse,
    output logic [7:0]              irq_count
);

    localparam logic [7:0]       PHASE_V = 8'(IRQ_PHASE);
    localparam logic [7:0]       LAST_V  = 8'(IRQ_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Low for the first edge after reset: that edge only latches the divisors.
    logic live_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] per_q, per_d;
            logic [CNT_W-1:0] per_eff;
            logic             at_end;

            assign per_eff = (per_q == '0) ? ONE : per_q;
            assign at_end  = (cnt_q == per_eff - ONE);
            assign ce[gi]  = live_q & run & ~resync & at_end;
            assign sq[gi]  = (cnt_q >= (per_eff >> 1));

            always_comb begin
                cnt_d = cnt_q;
                per_d = per_q;
                if (!live_q || resync) begin
                    cnt_d = '0;
                    per_d = div[gi*CNT_W +: CNT_W];
                end else if (run) begin
                    if (at_end) begin
                        // Divisor is only sampled at the period boundary.
                        cnt_d = '0;
                        per_d = div[gi*CNT_W +: CNT_W];
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    per_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    per_q <= per_d;
                end
            end
        end
    endgenerate

    logic [7:0] irq_cnt_q, irq_cnt_d;
    logic       irq_q, irq_d;
    logic       irq_pulse_q;
    logic       src_ce;
    logic       irq_set;

    assign src_ce  = ce[IRQ_SRC];
    assign irq_set = src_ce && (irq_cnt_q == PHASE_V);

    always_comb begin
        irq_cnt_d = irq_cnt_q;
        if (!live_q || resync) begin
            irq_cnt_d = '0;
        end else if (src_ce) begin
            irq_cnt_d = (irq_cnt_q == LAST_V) ? 8'd0 : irq_cnt_q + 8'd1;
        end
        // A set event outranks a simultaneous acknowledge.
        irq_d = irq_set ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= 1'b0;
            irq_cnt_q   <= '0;
            irq_q       <= 1'b0;
            irq_pulse_q <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            irq_cnt_q   <= irq_cnt_d;
            irq_q       <= irq_d;
            irq_pulse_q <= irq_set;
        end
    end

    assign irq       = irq_q;
    assign irq_pulse = irq_pulse_q;
    assign irq_count = irq_cnt_q;

endmodule

// File: tb/tb_ce_timer_bank.sv
// Directed bench for ce_timer_bank: divider timing, divisor reload, interrupt
// phase and acknowledge priority, run/resync behaviour and asynchronous reset.
module tb_ce_timer_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    run;
    logic                    resync;
    logic [NUM_CH*CNT_W-1:0] div;
    logic                    irq_ack;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       sq;
    logic                    irq;
    logic                    irq_pulse;
    logic [7:0]              irq_count;

    int total = 0;
    int bad   = 0;

    ce_timer_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .IRQ_SRC(2), .IRQ_PERIOD(14), .IRQ_PHASE(12)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .resync(resync), .div(div),
        .irq_ack(irq_ack), .ce(ce), .sq(sq), .irq(irq),
        .irq_pulse(irq_pulse), .irq_count(irq_count)
    );

    always #5 clk = ~clk;

    task automatic set_div(input int d0, input int d1, input int d2);
        div = {16'(d2), 16'(d1), 16'(d0)};
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+3.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_resync();
        resync = 1'b1;
        #2;
        total++;
        if (ce !== 3'b000) begin
            bad++;
            $display("FAIL resync_ce: got %b want 000", ce);
        end
        next_cycle();
        resync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; resync = 1'b0; irq_ack = 1'b0;
        set_div(16, 16384, 8192);
        repeat (3) @(posedge clk);
        #3;
        total++;
        if ({ce, sq, irq, irq_pulse, irq_count} !== {3'b000, 3'b111, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_state: got ce=%b sq=%b irq=%b pulse=%b cnt=%0d want ce=000 sq=111 irq=0 pulse=0 cnt=0",
                     ce, sq, irq, irq_pulse, irq_count);
        end
        next_cycle();
        rst = 1'b0;
        #2;
        total++;
        if ({ce, irq_pulse} !== 4'b0000) begin
            bad++;
            $display("FAIL release_cycle: got ce=%b pulse=%b want 0", ce, irq_pulse);
        end
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int n0 = 0, n1 = 0, n2 = 0, first1 = -1, first2 = -1;
        for (int c = 0; c < 16384; c++) begin
            #2;
            if (c < 64) begin
                total++;
                if (ce[0] !== (c % 16 == 15) || sq[0] !== (c % 16 >= 8)) begin
                    bad++;
                    $display("FAIL basic_ch0 c=%0d: got ce=%b sq=%b want ce=%b sq=%b",
                             c, ce[0], sq[0], (c % 16 == 15), (c % 16 >= 8));
                end
            end
            if (ce[0] === 1'b1) n0++;
            if (ce[1] === 1'b1) begin n1++; if (first1 < 0) first1 = c; end
            if (ce[2] === 1'b1) begin n2++; if (first2 < 0) first2 = c; end
            next_cycle();
        end
        #2;
        total++;
        if (n0 != 1024) begin bad++; $display("FAIL basic_n0: got %0d want 1024", n0); end
        total++;
        if (n1 != 1 || first1 != 16383) begin
            bad++; $display("FAIL basic_ch1: got n=%0d first=%0d want n=1 first=16383", n1, first1);
        end
        total++;
        if (n2 != 2 || first2 != 8191) begin
            bad++; $display("FAIL basic_ch2: got n=%0d first=%0d want n=2 first=8191", n2, first2);
        end
        total++;
        if (irq_count !== 8'd2) begin bad++; $display("FAIL basic_irq_count: got %0d want 2", irq_count); end
        $display("test_basic done");
    endtask

    task automatic test_div_change();
        set_div(16, 16384, 8192);
        do_resync();
        for (int c = 0; c < 32; c++) begin
            if (c == 5) set_div(4, 16384, 8192);
            #2;
            total++;
            if (ce[0] !== (c == 15 || (c > 15 && (c - 15) % 4 == 0))) begin
                bad++;
                $display("FAIL div_change c=%0d: got ce0=%b want %b",
                         c, ce[0], (c == 15 || (c > 15 && (c - 15) % 4 == 0)));
            end
            next_cycle();
        end
        $display("test_div_change done");
    endtask

    task automatic test_irq();
        set_div(16, 16384, 4);
        irq_ack = 1'b1;
        do_resync();
        irq_ack = 1'b0;
        for (int c = 0; c < 120; c++) begin
            #2;
            total++;
            if (irq_count !== 8'((c / 4) % 14) || irq_pulse !== (c == 52 || c == 108) || irq !== (c >= 52)) begin
                bad++;
                $display("FAIL irq c=%0d: got cnt=%0d pulse=%b irq=%b want cnt=%0d pulse=%b irq=%b",
                         c, irq_count, irq_pulse, irq, (c / 4) % 14, (c == 52 || c == 108), (c >= 52));
            end
            next_cycle();
        end
        $display("test_irq done");
    endtask

    task automatic test_ack_collision();
        for (int c = 120; c < 171; c++) begin
            irq_ack = (c == 120 || c == 163 || c == 164);
            #2;
            total++;
            if (irq_count !== 8'((c / 4) % 14) || irq_pulse !== (c == 164) ||
                irq !== (c <= 120 || c == 164)) begin
                bad++;
                $display("FAIL ack c=%0d: got cnt=%0d pulse=%b irq=%b want cnt=%0d pulse=%b irq=%b",
                         c, irq_count, irq_pulse, irq, (c / 4) % 14, (c == 164), (c <= 120 || c == 164));
            end
            next_cycle();
        end
        irq_ack = 1'b0;
        $display("test_ack_collision done");
    endtask

    task automatic test_run_hold_resync();
        set_div(16, 1, 4);
        do_resync();
        for (int c = 0; c < 5; c++) begin
            #2;
            total++;
            if (ce[1] !== 1'b1) begin bad++; $display("FAIL hold_pre c=%0d: got ce1=%b want 1", c, ce[1]); end
            next_cycle();
        end
        run = 1'b0;
        for (int c = 5; c < 15; c++) begin
            #2;
            total++;
            if (ce !== 3'b000 || sq !== 3'b010 || irq_count !== 8'd1) begin
                bad++;
                $display("FAIL hold c=%0d: got ce=%b sq=%b cnt=%0d want ce=000 sq=010 cnt=1", c, ce, sq, irq_count);
            end
            next_cycle();
        end
        run = 1'b1;
        do_resync();
        for (int c = 0; c < 16; c++) begin
            #2;
            if (c == 0) begin
                total++;
                if (irq_count !== 8'd0 || sq !== 3'b010 || irq_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL after_resync: got cnt=%0d sq=%b pulse=%b want cnt=0 sq=010 pulse=0",
                             irq_count, sq, irq_pulse);
                end
            end
            total++;
            if (ce[0] !== (c == 15)) begin
                bad++; $display("FAIL resync_count c=%0d: got ce0=%b want %b", c, ce[0], (c == 15));
            end
            next_cycle();
        end
        $display("test_run_hold_resync done");
    endtask

    task automatic test_div_zero_async_rst();
        set_div(16, 0, 4);
        do_resync();
        for (int c = 0; c < 12; c++) begin
            if (c == 6) set_div(16, 1, 4);
            #2;
            total++;
            if (ce[1] !== 1'b1 || sq[1] !== 1'b1) begin
                bad++; $display("FAIL div01 c=%0d: got ce1=%b sq1=%b want 1 1", c, ce[1], sq[1]);
            end
            next_cycle();
        end
        #2;
        total++;
        if (irq_count !== 8'd3) begin bad++; $display("FAIL pre_rst_count: got %0d want 3", irq_count); end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({ce, sq, irq, irq_pulse, irq_count} !== {3'b000, 3'b111, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL async_rst: got ce=%b sq=%b irq=%b pulse=%b cnt=%0d want ce=000 sq=111 irq=0 pulse=0 cnt=0",
                     ce, sq, irq, irq_pulse, irq_count);
        end
        next_cycle();
        rst = 1'b0;
        #2;
        total++;
        if (ce !== 3'b000) begin bad++; $display("FAIL rst_release_ce: got %b want 000", ce); end
        next_cycle();
        #2;
        total++;
        if (ce !== 3'b010) begin bad++; $display("FAIL post_release_ce: got %b want 010", ce); end
        $display("test_div_zero_async_rst done");
    endtask

    initial begin
        test_reset();
        test_basic();
        next_cycle();
        test_div_change();
        test_irq();
        test_ack_collision();
        test_run_hold_resync();
        test_div_zero_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
